// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// The display shows a packed hex word held in a shadow register. The shadow
// register is only refreshed at frame boundaries, so a frame never shows a
// mix of old and new digits.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   value       hex word, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point request per digit (active-high)
//   digit_en    per-digit enable; 0 forces that digit dark
//   blank_zeros leading-zero blanking mode
//   load        single-cycle strobe capturing value/dp_in
//   an          anode selects, active-low, at most one low at a time
//   seven       segments {a,b,c,d,e,f,g}, active-low
//   dp          decimal point segment, active-low
//   scan_idx    index of the digit currently being scanned
//   frame_done  one-cycle pulse at the end of the last digit's slot
//
// Handshake: load is a strobe with no back-pressure. Every cycle with load=1
// is accepted, and the last load before a frame boundary wins. A load in
// the frame_done cycle bypasses the pending register and goes directly to
// shadow.
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [4*NUM_DIGITS-1:0]       value,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic [NUM_DIGITS-1:0]         digit_en,
   input  logic                          blank_zeros,
   input  logic                          load,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [6:0]                    seven,
   output logic                          dp,
   output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
   output logic                          frame_done
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);

   logic [CW-1:0]           cnt;
   logic                    wrap;
   logic                    last_digit;

   logic [4*NUM_DIGITS-1:0] pend_val;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic                    pend_valid;
   logic [4*NUM_DIGITS-1:0] shadow_val;
   logic [NUM_DIGITS-1:0]   shadow_dp;

   logic [NUM_DIGITS-1:0]   lz_dark;
   logic                    all_zero;
   logic [3:0]              nibble;
   logic                    dark;
   logic                    blank;
   logic [NUM_DIGITS-1:0]   an_next;
   logic [6:0]              seven_next;
   logic                    dp_next;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      case (n)
         4'h0: hex_decode = 7'b0000001;
         4'h1: hex_decode = 7'b1001111;
         4'h2: hex_decode = 7'b0010010;
         4'h3: hex_decode = 7'b0000110;
         4'h4: hex_decode = 7'b1001100;
         4'h5: hex_decode = 7'b0100100;
         4'h6: hex_decode = 7'b0100000;
         4'h7: hex_decode = 7'b0001111;
         4'h8: hex_decode = 7'b0000000;
         4'h9: hex_decode = 7'b0000100;
         4'hA: hex_decode = 7'b0001000;
         4'hB: hex_decode = 7'b1100000;
         4'hC: hex_decode = 7'b0110001;
         4'hD: hex_decode = 7'b1000010;
         4'hE: hex_decode = 7'b0110000;
         default: hex_decode = 7'b0111000;
      endcase
   endfunction

   assign wrap       = (cnt == CW'(SCAN_DIV - 1));
   assign last_digit = (scan_idx == IW'(NUM_DIGITS - 1));
   assign frame_done = wrap && last_digit;

   // Slot counter and digit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         scan_idx <= '0;
      end else if (wrap) begin
         cnt      <= '0;
         scan_idx <= last_digit ? '0 : scan_idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Double buffer: pending collects loads and shadow feeds the display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_valid <= 1'b0;
         shadow_val <= '0;
         shadow_dp  <= '0;
      end else if (frame_done) begin
         if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
         end else if (pend_valid) begin
            shadow_val <= pend_val;
            shadow_dp  <= pend_dp;
         end
         pend_valid <= 1'b0;
      end else if (load) begin
         pend_val   <= value;
         pend_dp    <= dp_in;
         pend_valid <= 1'b1;
      end
   end

   // lz_dark[i] is set when every nibble from the top down to i is zero.
   // Digit 0 is never included.
   always_comb begin
      lz_dark  = '0;
      all_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         all_zero   = all_zero & (shadow_val[4*i +: 4] == 4'h0);
         lz_dark[i] = all_zero;
      end
   end

   always_comb begin
      nibble     = shadow_val[4*scan_idx +: 4];
      dark       = !digit_en[scan_idx] || (blank_zeros && lz_dark[scan_idx]);
      blank      = (cnt < CW'(BLANK_CYCLES));
      an_next    = '1;
      seven_next = 7'b1111111;
      dp_next    = 1'b1;
      if (!blank) begin
         // A dark digit still gets its anode pulled low, so every slot has
         // the same duty cycle whether or not it shows anything.
         an_next[scan_idx] = 1'b0;
         if (!dark) begin
            seven_next = hex_decode(nibble);
            dp_next    = ~shadow_dp[scan_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an    <= '1;
         seven <= 7'b1111111;
         dp    <= 1'b1;
      end else begin
         an    <= an_next;
         seven <= seven_next;
         dp    <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4,
// BLANK_CYCLES=1. One full frame spans 16 cycles.
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst_n;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        blank_zeros;
   logic        load;
   logic [3:0]  an;
   logic [6:0]  seven;
   logic        dp;
   logic [1:0]  scan_idx;
   logic        frame_done;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   seg7_scan_driver #(
      .NUM_DIGITS  (4),
      .SCAN_DIV    (4),
      .BLANK_CYCLES(1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .blank_zeros(blank_zeros),
      .load       (load),
      .an         (an),
      .seven      (seven),
      .dp         (dp),
      .scan_idx   (scan_idx),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp_in = d;
      load  = 1'b1;
      step();
      load  = 1'b0;
   endtask

   // Returns just after the edge at which frame_done becomes visible.
   task automatic wait_frame();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (frame_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("frame_done_timeout", 32'(seen), 32'd1);
   endtask

   // Walks one whole frame starting from the frame_done point.
   // sev holds the expected segments {d3,d2,d1,d0}; dpe holds the expected
   // active-low dp level per digit.
   task automatic check_frame(input logic [27:0] sev, input logic [3:0] dpe);
      int t;
      int d;
      logic [3:0] ea;
      for (int n = 1; n <= 17; n++) begin
         step();
         if (n == 1) load = 1'b0;
         chk("scan_idx", 32'(scan_idx), 32'(((n - 1) / 4) % 4));
         chk("frame_done", 32'(frame_done), 32'(n == 16));
         if (n >= 2) begin
            t = n - 2;
            d = t / 4;
            if ((t % 4) < 1) begin
               chk("gap_an", 32'(an), 32'hF);
               chk("gap_seven", 32'(seven), 32'h7F);
               chk("gap_dp", 32'(dp), 32'd1);
            end else begin
               ea = 4'hF;
               ea[d] = 1'b0;
               chk("an", 32'(an), 32'(ea));
               chk("seven", 32'(seven), 32'(sev[d*7 +: 7]));
               chk("dp", 32'(dp), 32'(dpe[d]));
            end
         end
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      value       = 16'h0;
      dp_in       = 4'h0;
      digit_en    = 4'hF;
      blank_zeros = 1'b0;
      load        = 1'b0;

      // Reset values.
      repeat (3) step();
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seven", 32'(seven), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_scan_idx", 32'(scan_idx), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      rst_n = 1'b1;

      // Basic decode and scan timing for 1A2F.
      do_load(16'h1A2F, 4'h0);
      wait_frame();
      check_frame({7'b1001111, 7'b0001000, 7'b0010010, 7'b0111000}, 4'hF);

      // Two loads in one frame: only the last one shows on the next frame.
      do_load(16'h0000, 4'h0);
      step();
      do_load(16'h1234, 4'h0);
      wait_frame();
      check_frame({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'hF);

      // Load in the frame_done cycle goes directly to the next frame.
      wait_frame();
      value = 16'h5555;
      dp_in = 4'h0;
      load  = 1'b1;
      check_frame({4{7'b0100100}}, 4'hF);

      // Leading-zero blanking.
      blank_zeros = 1'b1;
      do_load(16'h0070, 4'h0);
      wait_frame();
      check_frame({7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}, 4'hF);
      do_load(16'h0000, 4'h0);
      wait_frame();
      check_frame({7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'hF);

      // Per-digit enable and decimal points. A value change without load
      // must not reach the display.
      blank_zeros = 1'b0;
      digit_en    = 4'b0101;
      do_load(16'h1A2F, 4'b0001);
      value = 16'hFFFF;
      dp_in = 4'hF;
      wait_frame();
      check_frame({7'b1111111, 7'b0001000, 7'b1111111, 7'b0111000}, 4'b1110);

      // Mid-slot reset: asynchronous clear, and pending data is discarded.
      digit_en = 4'hF;
      do_load(16'h1234, 4'h0);
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      chk("async_an", 32'(an), 32'hF);
      chk("async_seven", 32'(seven), 32'h7F);
      chk("async_dp", 32'(dp), 32'd1);
      chk("async_scan_idx", 32'(scan_idx), 32'd0);
      chk("async_frame_done", 32'(frame_done), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      wait_frame();
      check_frame({4{7'b0000001}}, 4'hF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
